// File: rtl/alu_seq_if.sv
// Request/response bundle for alu_seq: operand request channel and result channel.
// slave is the ALU side, master the requester side.
interface alu_seq_if #(
    parameter int unsigned W = 12
);
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   in_op;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_y;
    logic [W-1:0] out_hi;
    logic         out_zero;
    logic         out_illegal;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_y, out_hi, out_zero, out_illegal
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_y, out_hi, out_zero, out_illegal
    );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle add/sub/logic/shift, optional iterative shift-add multiplier.
// Define ALU_SEQ_MUL_EN to build the multiplier; otherwise opcode 111 returns out_illegal.
module alu_seq #(
    parameter int unsigned W = 12
) (
    input logic       clk,
    input logic       rst,
    alu_seq_if.slave  bus
);

`ifdef ALU_SEQ_MUL_EN
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
`else
    typedef enum logic [0:0] {IDLE, DONE} state_t;
`endif

    localparam logic [W-1:0] W_LIM = W[W-1:0];

    state_t       state;
    logic [W-1:0] y_r;
    logic [W-1:0] hi_r;
    logic         zero_r;
    logic         ill_r;

    logic [W-1:0] alu_y;
    logic [W-1:0] alu_hi;
    logic         alu_ill;
    logic [W:0]   add_full;

    always_comb begin
        alu_y    = '0;
        alu_hi   = '0;
        alu_ill  = 1'b0;
        add_full = {1'b0, bus.in_a} + {1'b0, bus.in_b};
        case (bus.in_op)
            3'b001: begin
                alu_y  = add_full[W-1:0];
                alu_hi = {{(W-1){1'b0}}, add_full[W]};
            end
            3'b010: begin
                alu_y  = bus.in_a - bus.in_b;
                alu_hi = {{(W-1){1'b0}}, (bus.in_a < bus.in_b)};
            end
            3'b011: alu_y = bus.in_a & bus.in_b;
            3'b100: alu_y = bus.in_a | bus.in_b;
            3'b101: alu_y = bus.in_a ^ bus.in_b;
            3'b110: begin
                if (bus.in_b < W_LIM)
                    alu_y = bus.in_a << bus.in_b;
            end
            3'b111: begin
`ifndef ALU_SEQ_MUL_EN
                alu_ill = 1'b1;
`endif
            end
            default: ;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    localparam int unsigned CW = $clog2(W);

    logic [W-1:0]   a_r;
    logic [2*W-1:0] prod_r;
    logic [2*W-1:0] prod_nx;
    logic [W:0]     mac;
    logic [CW-1:0]  cnt;

    // Multiplier lives in the low half of prod_r and is consumed LSB first as
    // partial sums shift in from the top.
    always_comb begin
        mac     = {1'b0, prod_r[2*W-1:W]} + (prod_r[0] ? {1'b0, a_r} : '0);
        prod_nx = {mac, prod_r[W-1:1]};
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            y_r    <= '0;
            hi_r   <= '0;
            zero_r <= 1'b0;
            ill_r  <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            a_r    <= '0;
            prod_r <= '0;
            cnt    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
`ifdef ALU_SEQ_MUL_EN
                        if (bus.in_op == 3'b111) begin
                            a_r    <= bus.in_a;
                            prod_r <= {{W{1'b0}}, bus.in_b};
                            cnt    <= '0;
                            state  <= EXEC;
                        end else
`endif
                        begin
                            y_r    <= alu_y;
                            hi_r   <= alu_hi;
                            zero_r <= (alu_y == '0) && (alu_hi == '0);
                            ill_r  <= alu_ill;
                            state  <= DONE;
                        end
                    end
                end
`ifdef ALU_SEQ_MUL_EN
                EXEC: begin
                    prod_r <= prod_nx;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(W - 1)) begin
                        y_r    <= prod_nx[W-1:0];
                        hi_r   <= prod_nx[2*W-1:W];
                        zero_r <= (prod_nx == '0);
                        ill_r  <= 1'b0;
                        state  <= DONE;
                    end
                end
`endif
                DONE: begin
                    if (bus.out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready    = (state == IDLE);
    assign bus.out_valid   = (state == DONE);
    assign bus.out_y       = y_r;
    assign bus.out_hi      = hi_r;
    assign bus.out_zero    = zero_r;
    assign bus.out_illegal = ill_r;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (W=12): vector table plus backpressure and reset sequences.
// Expectations for opcode 111 follow ALU_SEQ_MUL_EN.
module tb_alu_seq;
    localparam int unsigned W = 12;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_seq_if #(.W(W)) bus ();
    alu_seq #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    typedef struct {
        string        name;
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] y;
        logic [W-1:0] hi;
        logic         zero;
        logic         ill;
        int           lat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string n, input logic [2:0] op,
                                input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] y, input logic [W-1:0] hi,
                                input logic zero, input logic ill, input int lat);
        vec_t v;
        v.name = n; v.op = op; v.a = a; v.b = b; v.y = y; v.hi = hi;
        v.zero = zero; v.ill = ill; v.lat = lat;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_valid"},   32'(bus.out_valid),   32'd0);
        check({tag, "_y"},       32'(bus.out_y),       32'd0);
        check({tag, "_hi"},      32'(bus.out_hi),      32'd0);
        check({tag, "_zero"},    32'(bus.out_zero),    32'd0);
        check({tag, "_illegal"}, 32'(bus.out_illegal), 32'd0);
    endtask

    // Waits (bounded) for in_ready, presents one request, scrambles the inputs
    // after the accept edge and counts edges until out_valid.
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, output int lat);
        int waited = 0;
        while (bus.in_ready !== 1'b1 && waited < 50) begin
            tick();
            waited++;
        end
        check("accept_ready", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        tick();
        bus.in_valid = 1'b0;
        bus.in_op    = 3'($urandom);
        bus.in_a     = W'($urandom);
        bus.in_b     = W'($urandom);
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [W-1:0] held_y;

        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b1;
        rst           = 1'b1;

        vecs.push_back(mk("add_wrap",  3'b001, 12'hFFF, 12'h001, 12'h000, 12'h001, 1'b0, 1'b0, 1));
        vecs.push_back(mk("sub_neg",   3'b010, 12'h005, 12'h007, 12'hFFE, 12'h001, 1'b0, 1'b0, 1));
        vecs.push_back(mk("sub_pos",   3'b010, 12'h007, 12'h005, 12'h002, 12'h000, 1'b0, 1'b0, 1));
        vecs.push_back(mk("shl_4",     3'b110, 12'h00F, 12'h004, 12'h0F0, 12'h000, 1'b0, 1'b0, 1));
        vecs.push_back(mk("shl_w",     3'b110, 12'h00F, 12'h00C, 12'h000, 12'h000, 1'b1, 1'b0, 1));
        vecs.push_back(mk("shl_max",   3'b110, 12'h001, 12'h00B, 12'h800, 12'h000, 1'b0, 1'b0, 1));
        vecs.push_back(mk("shl_big",   3'b110, 12'hFFF, 12'hFFF, 12'h000, 12'h000, 1'b1, 1'b0, 1));
        vecs.push_back(mk("and",       3'b011, 12'hA5A, 12'h0FF, 12'h05A, 12'h000, 1'b0, 1'b0, 1));
        vecs.push_back(mk("or",        3'b100, 12'hA00, 12'h05A, 12'hA5A, 12'h000, 1'b0, 1'b0, 1));
        vecs.push_back(mk("xor",       3'b101, 12'hFFF, 12'h0F0, 12'hF0F, 12'h000, 1'b0, 1'b0, 1));
        vecs.push_back(mk("nop",       3'b000, 12'h123, 12'h456, 12'h000, 12'h000, 1'b1, 1'b0, 1));
        vecs.push_back(mk("add_zero",  3'b001, 12'h000, 12'h000, 12'h000, 12'h000, 1'b1, 1'b0, 1));
`ifdef ALU_SEQ_MUL_EN
        vecs.push_back(mk("mul_max",   3'b111, 12'hFFF, 12'hFFF, 12'h001, 12'hFFE, 1'b0, 1'b0, 13));
        vecs.push_back(mk("mul_small", 3'b111, 12'h003, 12'h005, 12'h00F, 12'h000, 1'b0, 1'b0, 13));
        vecs.push_back(mk("mul_carry", 3'b111, 12'h800, 12'h002, 12'h000, 12'h001, 1'b0, 1'b0, 13));
        vecs.push_back(mk("mul_zero",  3'b111, 12'h000, 12'hABC, 12'h000, 12'h000, 1'b1, 1'b0, 13));
`else
        vecs.push_back(mk("mul_max",   3'b111, 12'hFFF, 12'hFFF, 12'h000, 12'h000, 1'b1, 1'b1, 1));
        vecs.push_back(mk("mul_small", 3'b111, 12'h003, 12'h005, 12'h000, 12'h000, 1'b1, 1'b1, 1));
`endif
        vecs.push_back(mk("add_after", 3'b001, 12'h7FF, 12'h001, 12'h800, 12'h000, 1'b0, 1'b0, 1));

        tick();
        tick();
        check_cleared("reset");
        rst = 1'b0;
        tick();
        check("reset_release_ready", 32'(bus.in_ready), 32'd1);

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
            check({vecs[i].name, "_lat"},     32'(lat),             32'(vecs[i].lat));
            check({vecs[i].name, "_y"},       32'(bus.out_y),       32'(vecs[i].y));
            check({vecs[i].name, "_hi"},      32'(bus.out_hi),      32'(vecs[i].hi));
            check({vecs[i].name, "_zero"},    32'(bus.out_zero),    32'(vecs[i].zero));
            check({vecs[i].name, "_illegal"}, 32'(bus.out_illegal), 32'(vecs[i].ill));
            tick();
            check({vecs[i].name, "_idle"},    32'(bus.in_ready),    32'd1);
        end

        // Backpressure: result and in_ready must hold while a competing request is offered.
        bus.out_ready = 1'b0;
        run_op(3'b001, 12'h100, 12'h023, lat);
        check("bp_lat", 32'(lat), 32'd1);
        held_y = 12'h123;
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = 1'b1;
            bus.in_op    = 3'b011;
            bus.in_a     = 12'h000;
            bus.in_b     = 12'h000;
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_ready", 32'(bus.in_ready),  32'd0);
            check("bp_y",     32'(bus.out_y),     32'(held_y));
            check("bp_hi",    32'(bus.out_hi),    32'd0);
            check("bp_zero",  32'(bus.out_zero),  32'd0);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("bp_release_valid", 32'(bus.out_valid), 32'd0);
        check("bp_release_ready", 32'(bus.in_ready),  32'd1);

        // Reset while a result is waiting in DONE.
        bus.out_ready = 1'b0;
        run_op(3'b100, 12'hF00, 12'h00F, lat);
        check("done_rst_pre_y", 32'(bus.out_y), 32'hF0F);
        rst = 1'b1;
        tick();
        check_cleared("done_rst");
        rst = 1'b0;
        bus.out_ready = 1'b1;
        check("done_rst_ready", 32'(bus.in_ready), 32'd1);
        run_op(3'b001, 12'h002, 12'h003, lat);
        check("done_rst_add_lat", 32'(lat), 32'd1);
        check("done_rst_add_y", 32'(bus.out_y), 32'd5);
        tick();

`ifdef ALU_SEQ_MUL_EN
        // Reset on the third EXEC cycle of a multiply.
        bus.in_valid = 1'b1;
        bus.in_op    = 3'b111;
        bus.in_a     = 12'hFFF;
        bus.in_b     = 12'hFFF;
        tick();
        bus.in_valid = 1'b0;
        check("mul_rst_exec_ready", 32'(bus.in_ready), 32'd0);
        tick();
        tick();
        check("mul_rst_exec_valid", 32'(bus.out_valid), 32'd0);
        rst = 1'b1;
        tick();
        check_cleared("mul_rst");
        rst = 1'b0;
        tick();
        check("mul_rst_ready", 32'(bus.in_ready), 32'd1);
        run_op(3'b001, 12'h002, 12'h003, lat);
        check("mul_rst_add_lat",  32'(lat),          32'd1);
        check("mul_rst_add_y",    32'(bus.out_y),    32'd5);
        check("mul_rst_add_hi",   32'(bus.out_hi),   32'd0);
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter W, default 12, operand and result width in bits (legal range 4..32).
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, operation request present.
REQ-005 SHALL have port in_ready, output, 1, block accepts a request this cycle.
REQ-006 SHALL have port in_op, input, 3, opcode.
REQ-007 SHALL have port in_a, input, W, first operand.
REQ-008 SHALL have port in_b, input, W, second operand.
REQ-009 SHALL have port out_valid, output, 1, result available.
REQ-010 SHALL have port out_ready, input, 1, consumer takes result.
REQ-011 SHALL have port out_y, output, W, result low word.
REQ-012 SHALL have port out_hi, output, W, result high word (carry or product upper half).
REQ-013 SHALL have port out_zero, output, 1, set when out_y and out_hi are both zero.
REQ-014 SHALL have port out_illegal, output, 1, opcode not supported in this build.

Function
REQ-015 SHALL implement the FSM states IDLE, EXEC and DONE; in_ready is 1 only in IDLE.
REQ-016 SHALL accept a request when in_valid && in_ready, capturing in_op, in_a and in_b into internal registers; later input changes have no effect.
REQ-017 SHALL implement the opcodes: 000 NOP -> y=0; 001 ADD -> y=a+b mod 2^W, hi=carry out; 010 SUB -> y=a-b mod 2^W, hi=1 iff a<b unsigned; 011 AND; 100 OR; 101 XOR (logic ops: hi=0).
REQ-018 SHALL implement opcode 110 SHL as y=a<<b (unsigned) with hi=0, and SHALL give y=0 when b>=W.
REQ-019 SHALL implement opcode 111 MUL as the unsigned product {hi,y}=a*b, computed iteratively by shift-add, one partial-product step per cycle.
REQ-020 SHALL move single-cycle ops from IDLE to DONE on accept, so out_valid rises on the cycle after the accept edge (latency 1).
REQ-021 SHALL move MUL from IDLE to EXEC on accept, spend exactly W cycles in EXEC, then go to DONE (latency W+1).
REQ-022 SHALL assert out_valid only in DONE, and hold out_y, out_hi, out_zero and out_illegal stable while out_valid && !out_ready.
REQ-023 SHALL return from DONE to IDLE on the edge where out_valid && out_ready; no new request is accepted in that same cycle.
REQ-024 SHALL keep the result from one request independent of all previous requests (no accumulator carry-over).
REQ-025 SHALL ignore in_valid in EXEC and DONE; the requester holds the request until in_ready.

Reset
REQ-026 SHALL, while rst=1 at a clock edge, enter IDLE and clear out_valid, out_y, out_hi, out_zero, out_illegal and all operand, iteration and product registers.
REQ-027 SHALL abort any operation in progress in EXEC or DONE on reset and drop the result; the first cycle after reset deasserts has in_ready=1.

Configuration
REQ-028 SHALL, with macro ALU_SEQ_MUL_EN defined, implement MUL per REQ-019/021 with out_illegal=0.
REQ-029 SHALL, without ALU_SEQ_MUL_EN, omit the multiplier datapath and the EXEC state, and treat opcode 111 as a latency-1 op with y=0, hi=0, out_zero=1 and out_illegal=1.

Verification
REQ-030 SHALL cover ADD, W=12: a=12'hFFF, b=12'h001 -> one cycle later out_valid=1, y=0, hi=1, out_zero=0.
REQ-031 SHALL cover SUB, W=12: a=5, b=7 -> y=12'hFFE, hi=1; then a=7, b=5 -> y=2, hi=0.
REQ-032 SHALL cover SHL, W=12: a=12'h00F, b=4 -> y=12'h0F0; then b=12 -> y=0, out_zero=1.
REQ-033 SHALL cover MUL with ALU_SEQ_MUL_EN, W=12: a=12'hFFF, b=12'hFFF -> out_valid exactly 13 cycles after accept, hi=12'hFFE, y=12'h001; same stimulus without the macro -> latency 1, out_illegal=1.
REQ-034 SHALL cover backpressure: hold out_ready=0 for 5 cycles after out_valid -> outputs stable and in_ready=0 throughout; out_ready=1 -> IDLE on the next edge.
REQ-035 SHALL cover reset mid-MUL: assert rst at EXEC cycle 3 -> next cycle out_valid=0 and all outputs zero; after release in_ready=1 and an ADD of 2+3 returns y=5.
